// File: rtl/fft_in_framer.sv
// rtl/fft_in_framer.sv - input framer packing 512 complex samples into 32x16-lane vectors
// Two ping-pong banks; each full bank is replayed as an unbroken 32-cycle burst.
module fft_in_framer #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_IN_OUT = 16,
    parameter int FRAME_LEN  = 512
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_i,
    input  logic signed [DATA_WIDTH-1:0] s_q,
    input  logic                         s_last,
    output logic signed [DATA_WIDTH-1:0] dout_i [0:NUM_IN_OUT-1],
    output logic signed [DATA_WIDTH-1:0] dout_q [0:NUM_IN_OUT-1],
    output logic                         dout_valid,
    output logic                         frame_start,
    output logic                         frame_err
);
    localparam int VEC_PER_FRAME = FRAME_LEN / NUM_IN_OUT;
    localparam int LANE_W = $clog2(NUM_IN_OUT);
    localparam int VEC_W  = $clog2(VEC_PER_FRAME);
    localparam int WP_W   = LANE_W + VEC_W;
    localparam logic [WP_W-1:0]  WP_LAST = WP_W'(FRAME_LEN - 1);
    localparam logic [VEC_W-1:0] RV_LAST = VEC_W'(VEC_PER_FRAME - 1);

    typedef enum logic {IDLE, BURST} state_t;

    logic signed [DATA_WIDTH-1:0] mem_i [2][VEC_PER_FRAME][NUM_IN_OUT];
    logic signed [DATA_WIDTH-1:0] mem_q [2][VEC_PER_FRAME][NUM_IN_OUT];
    logic signed [DATA_WIDTH-1:0] dout_i_q [0:NUM_IN_OUT-1];
    logic signed [DATA_WIDTH-1:0] dout_q_q [0:NUM_IN_OUT-1];

    logic             rstn_q;
    logic [WP_W-1:0]  wp_q, wp_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             err_q, err_d;
    state_t           state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [VEC_W-1:0] rv_q, rv_d;
    logic             valid_q, start_q;

    logic             accept, frame_end, frame_good;
    logic             load, load_bank, clr;
    logic [VEC_W-1:0] load_vec;

    assign s_ready    = rstn_q && !full_q[wr_bank_q];
    assign accept     = s_valid && s_ready;
    assign frame_end  = accept && (s_last || wp_q == WP_LAST);
    assign frame_good = frame_end && s_last && wp_q == WP_LAST;

    always_comb begin
        wp_d      = wp_q;
        wr_bank_d = wr_bank_q;
        err_d     = 1'b0;
        if (frame_end) begin
            wp_d = '0;
            if (frame_good) wr_bank_d = ~wr_bank_q;
            else            err_d     = 1'b1;
        end else if (accept) begin
            wp_d = wp_q + 1'b1;
        end
    end

    // rv tracks the vector currently on the output; load picks the one shown next cycle.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rv_d      = rv_q;
        load      = 1'b0;
        load_bank = rd_bank_q;
        load_vec  = '0;
        clr       = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = BURST;
                    rv_d    = '0;
                    load    = 1'b1;
                end
            end
            BURST: begin
                if (rv_q == RV_LAST) begin
                    clr       = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rv_d      = '0;
                    if (full_q[~rd_bank_q]) begin
                        load      = 1'b1;
                        load_bank = ~rd_bank_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rv_d     = rv_q + 1'b1;
                    load     = 1'b1;
                    load_vec = rv_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set and clear always address different banks.
    always_comb begin
        full_d = full_q;
        if (clr)        full_d[rd_bank_q] = 1'b0;
        if (frame_good) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstn_q    <= 1'b0;
            wp_q      <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            err_q     <= 1'b0;
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            rv_q      <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            rstn_q    <= 1'b1;
            wp_q      <= wp_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            err_q     <= err_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rv_q      <= rv_d;
            valid_q   <= load;
            start_q   <= load && (load_vec == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_i[wr_bank_q][wp_q[WP_W-1:LANE_W]][wp_q[LANE_W-1:0]] <= s_i;
            mem_q[wr_bank_q][wp_q[WP_W-1:LANE_W]][wp_q[LANE_W-1:0]] <= s_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_IN_OUT; l++) begin
            if (!rstn || !load) begin
                dout_i_q[l] <= '0;
                dout_q_q[l] <= '0;
            end else begin
                dout_i_q[l] <= mem_i[load_bank][load_vec][l];
                dout_q_q[l] <= mem_q[load_bank][load_vec][l];
            end
        end
    end

    assign dout_i      = dout_i_q;
    assign dout_q      = dout_q_q;
    assign dout_valid  = valid_q;
    assign frame_start = start_q;
    assign frame_err   = err_q;
endmodule

// File: tb/tb_fft_in_framer.sv
// tb/tb_fft_in_framer.sv - directed self-checking bench for fft_in_framer
module tb_fft_in_framer;
    localparam int DW = 9;
    localparam int NL = 16;
    localparam int FL = 512;
    localparam int NV = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic s_ready;
    logic signed [DW-1:0] s_i = '0;
    logic signed [DW-1:0] s_q = '0;
    logic signed [DW-1:0] dout_i [0:NL-1];
    logic signed [DW-1:0] dout_q [0:NL-1];
    logic dout_valid, frame_start, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_low = 0;
    int idle_nz = 0;
    bit mon_ready = 1'b0;
    int cap_cyc[$];
    bit cap_start[$];
    int cap_i[$];
    int cap_q[$];
    int err_cyc[$];

    fft_in_framer #(.DATA_WIDTH(DW), .NUM_IN_OUT(NL), .FRAME_LEN(FL)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_i(s_i), .s_q(s_q), .s_last(s_last),
        .dout_i(dout_i), .dout_q(dout_q), .dout_valid(dout_valid),
        .frame_start(frame_start), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            cap_cyc.push_back(cyc);
            cap_start.push_back(frame_start);
            for (int l = 0; l < NL; l++) begin
                cap_i.push_back(int'(dout_i[l]));
                cap_q.push_back(int'(dout_q[l]));
            end
        end else if (dout_valid === 1'b0) begin
            for (int l = 0; l < NL; l++)
                if (dout_i[l] !== '0 || dout_q[l] !== '0) idle_nz++;
            if (frame_start !== 1'b0) idle_nz++;
        end
        if (frame_err === 1'b1) err_cyc.push_back(cyc);
        if (mon_ready && s_ready !== 1'b1) ready_low++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int ei(input int base, input int n);
        return ((n + base) % FL) - 256;
    endfunction

    function automatic int eq(input int base, input int n);
        return 255 - ((n + base) % FL);
    endfunction

    task automatic send_frame(input int len, input bit with_last, input int base,
                              input int gap, output int last_cyc);
        last_cyc = -1;
        for (int n = 0; n < len; n++) begin
            int w;
            bit acc;
            while (gap > 0 && int'($urandom_range(99)) < gap) begin
                s_valid = 1'b0;
                step(1);
            end
            s_valid = 1'b1;
            s_i = DW'(ei(base, n));
            s_q = DW'(eq(base, n));
            s_last = with_last && (n == len - 1);
            w = 0;
            acc = 1'b0;
            while (!acc && w < 2000) begin
                @(negedge clk);
                acc = s_ready;
                last_cyc = cyc;
                step(1);
                w++;
            end
            if (!acc) begin
                chk("ready_timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int v0, input int base, input int exp_cyc);
        int bad_seq, bad_start, bad_d, n;
        bad_seq = 0;
        bad_start = 0;
        bad_d = 0;
        if (cap_cyc.size() < v0 + NV) begin
            chk({tag, "_count"}, cap_cyc.size() - v0, NV);
            return;
        end
        chk({tag, "_v0_cycle"}, cap_cyc[v0], exp_cyc);
        for (int k = 0; k < NV; k++) begin
            if (cap_cyc[v0+k] != cap_cyc[v0] + k) bad_seq++;
            if (cap_start[v0+k] != (k == 0)) bad_start++;
            for (int l = 0; l < NL; l++) begin
                n = 16 * k + l;
                if (cap_i[(v0+k)*NL+l] != ei(base, n)) bad_d++;
                if (cap_q[(v0+k)*NL+l] != eq(base, n)) bad_d++;
            end
        end
        chk({tag, "_gaps"}, bad_seq, 0);
        chk({tag, "_frame_start"}, bad_start, 0);
        chk({tag, "_data"}, bad_d, 0);
    endtask

    initial begin
        int v0, e0, nz0, lc, lc2, nz;
        int lcs[4];

        // reset state
        rstn = 1'b0;
        step(3);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_err", frame_err, 0);
        rstn = 1'b1;
        step(1);
        chk("post_rst_s_ready", s_ready, 1);

        // single frame, continuous
        v0 = cap_cyc.size();
        nz0 = idle_nz;
        send_frame(FL, 1'b1, 0, 0, lc);
        step(40);
        chk("single_vec_total", cap_cyc.size() - v0, NV);
        check_burst("single", v0, 0, lc + 2);
        chk("single_idle_zero", idle_nz - nz0, 0);

        // four frames back-to-back
        v0 = cap_cyc.size();
        mon_ready = 1'b1;
        send_frame(FL, 1'b1, 0, 0, lcs[0]);
        send_frame(FL, 1'b1, 7, 0, lcs[1]);
        send_frame(FL, 1'b1, 100, 0, lcs[2]);
        send_frame(FL, 1'b1, 300, 0, lcs[3]);
        mon_ready = 1'b0;
        step(40);
        chk("b2b_ready_low", ready_low, 0);
        chk("b2b_vec_total", cap_cyc.size() - v0, 4 * NV);
        check_burst("b2b0", v0, 0, lcs[0] + 2);
        check_burst("b2b1", v0 + NV, 7, lcs[1] + 2);
        check_burst("b2b2", v0 + 2 * NV, 100, lcs[2] + 2);
        check_burst("b2b3", v0 + 3 * NV, 300, lcs[3] + 2);
        if (cap_cyc.size() >= v0 + 4 * NV)
            chk("b2b_period", cap_cyc[v0 + 3 * NV] - cap_cyc[v0 + 2 * NV], 512);

        // random input gaps
        v0 = cap_cyc.size();
        e0 = err_cyc.size();
        nz0 = idle_nz;
        send_frame(FL, 1'b1, 0, 30, lc);
        step(40);
        chk("gap_vec_total", cap_cyc.size() - v0, NV);
        check_burst("gap", v0, 0, lc + 2);
        chk("gap_idle_zero", idle_nz - nz0, 0);
        chk("gap_no_err", err_cyc.size() - e0, 0);

        // early s_last then good frame
        v0 = cap_cyc.size();
        e0 = err_cyc.size();
        send_frame(101, 1'b1, 0, 0, lc);
        send_frame(FL, 1'b1, 50, 0, lc2);
        step(40);
        chk("early_err_count", err_cyc.size() - e0, 1);
        if (err_cyc.size() > e0) chk("early_err_cycle", err_cyc[e0], lc + 1);
        chk("early_vec_total", cap_cyc.size() - v0, NV);
        check_burst("early_good", v0, 50, lc2 + 2);

        // missing s_last then good frame
        v0 = cap_cyc.size();
        e0 = err_cyc.size();
        send_frame(FL, 1'b0, 0, 0, lc);
        send_frame(FL, 1'b1, 200, 0, lc2);
        step(40);
        chk("nolast_err_count", err_cyc.size() - e0, 1);
        if (err_cyc.size() > e0) chk("nolast_err_cycle", err_cyc[e0], lc + 1);
        chk("nolast_vec_total", cap_cyc.size() - v0, NV);
        check_burst("nolast_good", v0, 200, lc2 + 2);

        // reset during burst vector 10
        v0 = cap_cyc.size();
        send_frame(FL, 1'b1, 0, 0, lc);
        step(11);
        chk("mid_v10_valid", dout_valid, 1);
        chk("mid_v10_lane0", int'(dout_i[0]), 16 * 10 - 256);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        nz = 0;
        for (int l = 0; l < NL; l++)
            if (dout_i[l] !== '0 || dout_q[l] !== '0) nz++;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_start", frame_start, 0);
        chk("mid_rst_lanes", nz, 0);
        chk("mid_rst_ready", s_ready, 0);
        step(1);
        chk("mid_rst_ready_back", s_ready, 1);
        chk("mid_pre_vecs", cap_cyc.size() - v0, 11);
        v0 = cap_cyc.size();
        step(40);
        chk("mid_no_remnant", cap_cyc.size() - v0, 0);
        send_frame(FL, 1'b1, 123, 0, lc);
        step(40);
        chk("mid_after_total", cap_cyc.size() - v0, NV);
        check_burst("mid_after", v0, 123, lc + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
